// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and width defaults for the memory bus arbiter
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_WAIT_CYC   = 2;
    localparam int DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - pipeline fetch/data ports and memory bus bundled for the arbiter
interface mem_bus_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;
    logic              stall_if;
    logic              stall_mem;
    logic [ADDR_W-1:0] MemBus_Address;
    logic [DATA_W-1:0] MemBus_Write_Data;
    logic              MemRead;
    logic              MemWrite;
    logic [DATA_W-1:0] Device_Read_Data;

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, Device_Read_Data,
        output if_rdata, if_ack, dm_rdata, dm_ack, stall_if, stall_mem,
        output MemBus_Address, MemBus_Write_Data, MemRead, MemWrite
    );

    // Pipeline plus memory side.
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, Device_Read_Data,
        input  if_rdata, if_ack, dm_rdata, dm_ack, stall_if, stall_mem,
        input  MemBus_Address, MemBus_Write_Data, MemRead, MemWrite
    );

endinterface

// File: rtl/mem_bus_arbiter_prio.sv
// rtl/mem_bus_arbiter_prio.sv - DM-over-IF grant selection with starvation override
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   arb_en,
    input  logic   if_req,
    input  logic   dm_req,
    output owner_e grant
);
    localparam int SW = cnt_w(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0] starve_cnt;
    logic          if_force;

    always_comb begin
        if_force = if_req && (starve_cnt == SMAX);
        grant    = OWN_IF;
        if (dm_req && !if_force) begin
            grant = OWN_DM;
        end
    end

    // Only an actual arbitration (IDLE with a request) moves the starvation count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (arb_en) begin
            if (grant == OWN_IF) begin
                starve_cnt <= '0;
            end else if (if_req && starve_cnt != SMAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one multi-cycle memory bus between fetch and load/store ports
// Optional stall cycle counters are built when MEMARB_PERF_CNT_EN is defined.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int WAIT_CYC   = DEF_WAIT_CYC,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                  sysclk,
    input  logic                  reset,
    mem_bus_arbiter_if.slave      bus
`ifdef MEMARB_PERF_CNT_EN
    ,
    output logic [31:0]           perf_if_stall_cnt,
    output logic [31:0]           perf_dm_stall_cnt
`endif
);
    localparam int CW = cnt_w(WAIT_CYC);
    localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYC - 1);

    state_e            state, state_n;
    owner_e            owner, grant;
    logic              we_q;
    logic [CW-1:0]     wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              start;
    logic              finish;
    logic              if_ack_w;
    logic              dm_ack_w;
    logic              stall_if_w;
    logic              stall_mem_w;

    mem_arb_prio #(.STARVE_MAX(STARVE_MAX)) u_prio (
        .clk    (sysclk),
        .rst_n  (reset),
        .arb_en (start),
        .if_req (bus.if_req),
        .dm_req (bus.dm_req),
        .grant  (grant)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // DONE always returns to IDLE without arbitrating, leaving one bubble between accesses.
    always_comb begin
        state_n = state;
        start   = 1'b0;
        finish  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    start   = 1'b1;
                    state_n = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt == '0) begin
                    finish  = 1'b1;
                    state_n = ST_DONE;
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            owner      <= OWN_IF;
            we_q       <= 1'b0;
            wait_cnt   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (start) begin
                owner    <= grant;
                wait_cnt <= WAIT_LOAD;
                if (grant == OWN_DM) begin
                    we_q    <= bus.dm_we;
                    addr_q  <= bus.dm_addr;
                    wdata_q <= bus.dm_wdata;
                end else begin
                    we_q    <= 1'b0;
                    addr_q  <= bus.if_addr;
                    wdata_q <= '0;
                end
            end else if (state == ST_ACCESS && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (finish && !we_q) begin
                if (owner == OWN_DM) begin
                    dm_rdata_q <= bus.Device_Read_Data;
                end else begin
                    if_rdata_q <= bus.Device_Read_Data;
                end
            end
        end
    end

    assign if_ack_w    = (state == ST_DONE) && (owner == OWN_IF);
    assign dm_ack_w    = (state == ST_DONE) && (owner == OWN_DM);
    assign stall_if_w  = bus.if_req & ~if_ack_w;
    assign stall_mem_w = bus.dm_req & ~dm_ack_w;

    assign bus.if_ack            = if_ack_w;
    assign bus.dm_ack            = dm_ack_w;
    assign bus.stall_if          = stall_if_w;
    assign bus.stall_mem         = stall_mem_w;
    assign bus.if_rdata          = if_rdata_q;
    assign bus.dm_rdata          = dm_rdata_q;
    assign bus.MemBus_Address    = addr_q;
    assign bus.MemBus_Write_Data = wdata_q;
    assign bus.MemRead           = (state == ST_ACCESS) && !we_q;
    assign bus.MemWrite          = (state == ST_ACCESS) && we_q;

`ifdef MEMARB_PERF_CNT_EN
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            perf_if_stall_cnt <= '0;
            perf_dm_stall_cnt <= '0;
        end else begin
            if (stall_if_w && perf_if_stall_cnt != '1) begin
                perf_if_stall_cnt <= perf_if_stall_cnt + 1'b1;
            end
            if (stall_mem_w && perf_dm_stall_cnt != '1) begin
                perf_dm_stall_cnt <= perf_dm_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed checks of arbitration, latency, starvation and reset
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    logic sysclk;
    logic reset;
    int   checks;
    int   errors;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef MEMARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_cnt;
    logic [31:0] perf_dm_stall_cnt;
    logic [31:0] p_if0;
    logic [31:0] p_dm0;
`endif

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .WAIT_CYC(2), .STARVE_MAX(4)
    ) dut (
        .sysclk            (sysclk),
        .reset             (reset),
        .bus               (bus)
`ifdef MEMARB_PERF_CNT_EN
        ,
        .perf_if_stall_cnt (perf_if_stall_cnt),
        .perf_dm_stall_cnt (perf_dm_stall_cnt)
`endif
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    int  dm_ack_cyc;
    int  if_ack_cyc;
    int  n_dm;
    int  max_starve;
    bit  if_done;

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        bus.dm_addr = '0;
        bus.dm_wdata = '0;
        bus.Device_Read_Data = '0;
        repeat (2) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);

        check("rst_memread", bus.MemRead, 1'b0);
        check("rst_memwrite", bus.MemWrite, 1'b0);
        check("rst_if_ack", bus.if_ack, 1'b0);
        check("rst_dm_ack", bus.dm_ack, 1'b0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_dm_rdata", bus.dm_rdata, 32'h0);
        check("rst_addr", bus.MemBus_Address, 32'h0);
        check("rst_wdata", bus.MemBus_Write_Data, 32'h0);
        check("rst_starve", dut.u_prio.starve_cnt, 3'd0);
`ifdef MEMARB_PERF_CNT_EN
        check("rst_perf_if", perf_if_stall_cnt, 32'd0);
        check("rst_perf_dm", perf_dm_stall_cnt, 32'd0);
`endif

        // IF-only fetch: strobe cycles 1-2, ack cycle 3.
        bus.if_addr = 32'h0040_0000;
        bus.Device_Read_Data = 32'h8C08_0004;
        bus.if_req = 1'b1;
        #1 check("s1_stall_c0", bus.stall_if, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge sysclk);
            check($sformatf("s1_memread_c%0d", c), bus.MemRead, (c <= 2));
            check($sformatf("s1_ack_c%0d", c), bus.if_ack, (c == 3));
            check($sformatf("s1_stall_c%0d", c), bus.stall_if, (c < 3));
            if (c == 1) check("s1_addr", bus.MemBus_Address, 32'h0040_0000);
            if (c == 3) begin
                check("s1_rdata", bus.if_rdata, 32'h8C08_0004);
                bus.if_req = 1'b0;
            end
        end

        // Store, with port address/data changed after grant.
        bus.dm_we = 1'b1;
        bus.dm_addr = 32'h1001_0000;
        bus.dm_wdata = 32'hDEAD_BEEF;
        bus.Device_Read_Data = 32'h1234_5678;
        bus.dm_req = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge sysclk);
            check($sformatf("s2_memwrite_c%0d", c), bus.MemWrite, (c <= 2));
            check($sformatf("s2_memread_c%0d", c), bus.MemRead, 1'b0);
            check($sformatf("s2_ack_c%0d", c), bus.dm_ack, (c == 3));
            if (c == 1 || c == 2) begin
                check($sformatf("s2_addr_c%0d", c), bus.MemBus_Address, 32'h1001_0000);
                check($sformatf("s2_wdata_c%0d", c), bus.MemBus_Write_Data, 32'hDEAD_BEEF);
                bus.dm_addr = 32'hFFFF_0000;
                bus.dm_wdata = 32'h0;
            end
            if (c == 3) begin
                check("s2_rdata", bus.dm_rdata, 32'h0);
                check("s2_if_ack", bus.if_ack, 1'b0);
                bus.dm_req = 1'b0;
                bus.dm_we = 1'b0;
            end
        end

        // Simultaneous load requests: DM first, IF on the next IDLE.
        bus.if_addr = 32'h0040_0004;
        bus.dm_addr = 32'h1001_0004;
        bus.Device_Read_Data = 32'hCAFE_F00D;
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
`ifdef MEMARB_PERF_CNT_EN
        p_if0 = perf_if_stall_cnt;
        p_dm0 = perf_dm_stall_cnt;
`endif
        dm_ack_cyc = -1;
        if_ack_cyc = -1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge sysclk);
            if (c == 1) check("s3_addr_dm", bus.MemBus_Address, 32'h1001_0004);
            if (c == 4) begin
                check("s3_stall_if_c4", bus.stall_if, 1'b1);
                check("s3_stall_mem_c4", bus.stall_mem, 1'b0);
            end
            if (c == 5) begin
                check("s3_addr_if", bus.MemBus_Address, 32'h0040_0004);
                check("s3_memread_c5", bus.MemRead, 1'b1);
            end
`ifdef MEMARB_PERF_CNT_EN
            if (c == 7) begin
                check("s3_perf_dm", perf_dm_stall_cnt - p_dm0, 32'd3);
                check("s3_perf_if", perf_if_stall_cnt - p_if0, 32'd7);
            end
`endif
            if (bus.dm_ack) begin
                dm_ack_cyc = c;
                bus.dm_req = 1'b0;
                bus.Device_Read_Data = 32'h1111_2222;
            end
            if (bus.if_ack) begin
                if_ack_cyc = c;
                bus.if_req = 1'b0;
            end
        end
        check("s3_dm_ack_cyc", 64'(dm_ack_cyc), 64'(3));
        check("s3_if_ack_cyc", 64'(if_ack_cyc), 64'(7));
        check("s3_dm_rdata", bus.dm_rdata, 32'hCAFE_F00D);
        check("s3_if_rdata", bus.if_rdata, 32'h1111_2222);

        // Continuous DM stores against a held fetch: IF forced after four losses.
        bus.dm_we = 1'b1;
        bus.dm_addr = 32'h1001_0008;
        bus.dm_wdata = 32'h0000_00AA;
        bus.dm_req = 1'b1;
        bus.if_req = 1'b1;
        n_dm = 0;
        max_starve = 0;
        if_done = 1'b0;
        if_ack_cyc = -1;
        for (int c = 1; c <= 60 && !if_done; c++) begin
            @(negedge sysclk);
            if (int'(dut.u_prio.starve_cnt) > max_starve) max_starve = int'(dut.u_prio.starve_cnt);
            if (bus.dm_ack) n_dm++;
            if (bus.if_ack) begin
                if_done = 1'b1;
                if_ack_cyc = c;
                bus.if_req = 1'b0;
                bus.dm_req = 1'b0;
                bus.dm_we = 1'b0;
            end
        end
        check("s4_if_done", if_done, 1'b1);
        check("s4_dm_wins", 64'(n_dm), 64'(4));
        check("s4_if_ack_cyc", 64'(if_ack_cyc), 64'(19));
        check("s4_max_starve", 64'(max_starve), 64'(4));
        check("s4_starve_clr", dut.u_prio.starve_cnt, 3'd0);

        // Reset during ACCESS: strobe drops at once, no ack, rdata cleared.
        @(negedge sysclk);
        bus.if_addr = 32'h0040_0008;
        bus.Device_Read_Data = 32'h0BAD_F00D;
        bus.if_req = 1'b1;
        @(negedge sysclk);
        check("s5_memread_pre", bus.MemRead, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("s5_memread_async", bus.MemRead, 1'b0);
        check("s5_if_rdata_clr", bus.if_rdata, 32'h0);
        check("s5_addr_clr", bus.MemBus_Address, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(negedge sysclk);
            check($sformatf("s5_no_ack_%0d", c), bus.if_ack, 1'b0);
            check($sformatf("s5_no_read_%0d", c), bus.MemRead, 1'b0);
        end
        reset = 1'b1;
        if_ack_cyc = -1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge sysclk);
            if (bus.if_ack && if_ack_cyc < 0) begin
                if_ack_cyc = c;
                bus.if_req = 1'b0;
            end
        end
        check("s5_ack_cyc", 64'(if_ack_cyc), 64'(3));
        check("s5_if_rdata", bus.if_rdata, 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the CPU's single data/instruction memory bus between the IF-stage fetch port and the MEM-stage load/store port.
- Sequences each access over a multi-cycle memory with fixed wait states.
- Returns read data and a one-cycle ack to the winning port.
- Drives per-port stall signals into the pipeline hazard logic. Sits between the CPU pipeline and the memory/device bus.

Parameters:
- ADDR_W, 32, bus address width
- DATA_W, 32, bus data width
- WAIT_CYC, 2, memory access cycles per transaction (legal range >=1)
- STARVE_MAX, 4, consecutive lost arbitrations after which IF is forced to win (legal range >=1)

Ports:
- sysclk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- if_req  in  1  fetch request, level, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, registered
- if_ack  out  1  one-cycle completion pulse
- dm_req  in  1  data request, level, held until dm_ack
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_ack  out  1  one-cycle completion pulse
- stall_if  out  1  if_req & ~if_ack, combinational
- stall_mem  out  1  dm_req & ~dm_ack, combinational
- MemBus_Address  out  ADDR_W  latched address of the current access
- MemBus_Write_Data  out  DATA_W  latched store data
- MemRead  out  1  read strobe
- MemWrite  out  1  write strobe
- Device_Read_Data  in  DATA_W  memory/device read data

Behaviour:
- Reset values: FSM in IDLE. All outputs 0: strobes, acks, rdata registers, bus address/data. Wait counter and starve counter 0. Reset is asynchronous, so strobes drop immediately.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - If either request is present, arbitrate, latch owner/addr/wdata/we onto the bus registers, load wait counter = WAIT_CYC-1, and go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration priority:
  - DM beats IF.
  - Exception: if starve_cnt == STARVE_MAX and if_req=1, IF wins.
  - starve_cnt increments (saturating at STARVE_MAX) when IF requested but lost. It clears when IF is granted.
- ACCESS:
  - MemRead = ~we, MemWrite = we; address/data held stable.
  - Counter decrements each cycle.
  - At counter == 0: capture Device_Read_Data into the owner's rdata register (loads/fetches only; dm_rdata is unchanged on a store), then go to DONE.
- DONE:
  - Strobes 0; owner's ack = 1 for exactly this cycle; go to IDLE.
  - No arbitration occurs in DONE, which guarantees one idle bubble between transactions.
- Latency: a request sampled in IDLE at cycle 0 gives strobes in cycles 1..WAIT_CYC and ack in cycle WAIT_CYC+1.
- Simultaneous requests: one is served at a time; the loser stays stalled and is arbitrated on the next IDLE.
- A request dropped mid-access is a protocol violation. The access still completes and ack still pulses; the bus is never aborted.
- Address/data changes on a held request after grant are ignored; latched values are used.
- Reset mid-access: the transaction is abandoned, no ack is issued, and previous rdata is cleared.

Optional Feature:
- Macro: MEMARB_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_if_stall_cnt (32) and perf_dm_stall_cnt (32).
  - Each counts cycles with stall_if / stall_mem high.
  - Counters saturate at all-ones and reset to 0.
- When undefined: the ports and counters do not exist; other behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - state enum {ST_IDLE, ST_ACCESS, ST_DONE}
  - owner enum {OWN_IF, OWN_DM}
  - default width constants
- Sub-module mem_arb_prio: combinational grant selection plus the starve_cnt register, instanced once.

Test Plan (WAIT_CYC=2, STARVE_MAX=4):
- Reset, then IF-only load: if_req=1, if_addr=0x00400000, device returns 0x8C080004 → MemRead high cycles 1-2, if_ack pulse cycle 3, if_rdata=0x8C080004, stall_if high cycles 0-2.
- Store: dm_req=1, dm_we=1, addr=0x10010000, wdata=0xDEADBEEF → MemWrite cycles 1-2 with bus holding these values, dm_ack cycle 3, dm_rdata unchanged.
- Simultaneous if_req and dm_req → DM served first (ack cycle 3), IF granted at cycle 4, if_ack at cycle 7.
- DM requests continuously with if_req held → IF loses 4 arbitrations, then the 5th is granted to IF; starve_cnt returns to 0.
- Reset asserted during ACCESS → strobes 0 asynchronously, no ack; after release the FSM is in IDLE and a new request completes normally.
- With MEMARB_PERF_CNT_EN defined, scenario 3 → perf_dm_stall_cnt=3, perf_if_stall_cnt=7.
